// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle of the register-file arbiter: requester handshakes,
// sweep control and the registered we3/a3/wd3 port.
interface regfile_write_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic                   clear;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [5*NREQ-1:0]      req_addr;
  logic [32*NREQ-1:0]     req_data;
  logic                   we3;
  logic [4:0]             a3;
  logic [31:0]            wd3;
  logic                   init_done;

  modport master (
    output clear, req_valid, req_addr, req_data,
    input  req_ready, we3, a3, wd3, init_done
  );

  modport slave (
    input  clear, req_valid, req_addr, req_data,
    output req_ready, we3, a3, wd3, init_done
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-sweeps x1..x(NREGS-1) after reset or
// on clear, then round-robin shares the port between NREQ writeback requesters.
module regfile_write_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned NREGS = 32
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = $clog2(NREGS);
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_ARB  = 1'b1;

  logic [0:0]       state,  state_nxt;
  logic [CNT_W-1:0] cnt,    cnt_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic             we3_q,  we3_nxt;
  logic [AW-1:0]    a3_q,   a3_nxt;
  logic [DW-1:0]    wd3_q,  wd3_nxt;

  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] sel_idx;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic             found;
  int unsigned      idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    idx      = 0;
    sel_idx  = rr_ptr;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!found && bus.req_valid[PTR_W'(idx)]) begin
        found                = 1'b1;
        grant[PTR_W'(idx)]   = 1'b1;
        sel_idx              = PTR_W'(idx);
        sel_addr             = AW'(bus.req_addr >> (AW * idx));
        sel_data             = DW'(bus.req_data >> (DW * idx));
      end
    end
    if (state != S_ARB || bus.clear) grant = '0;
  end

  // Next-state and write-port logic; we3 defaults low so idle cycles never write.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rr_ptr_nxt = rr_ptr;
    we3_nxt    = 1'b0;
    a3_nxt     = a3_q;
    wd3_nxt    = wd3_q;
    case (state)
      S_INIT: begin
        we3_nxt = 1'b1;
        a3_nxt  = AW'(cnt);
        wd3_nxt = '0;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(NREGS - 1)) begin
          state_nxt = S_ARB;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_ARB: begin
        if (bus.clear) begin
          state_nxt = S_INIT;
          cnt_nxt   = CNT_W'(1);
        end else if (|grant) begin
          rr_ptr_nxt = sel_idx;
          a3_nxt     = sel_addr;
          wd3_nxt    = sel_data;
          // x0 writes are consumed but never reach the register file
          we3_nxt    = (sel_addr != '0);
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_INIT;
      cnt    <= CNT_W'(1);
      rr_ptr <= PTR_W'(NREQ - 1);
      we3_q  <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rr_ptr <= rr_ptr_nxt;
      we3_q  <= we3_nxt;
      a3_q   <= a3_nxt;
      wd3_q  <= wd3_nxt;
    end
  end

  assign bus.req_ready = grant;
  assign bus.we3       = we3_q;
  assign bus.a3        = a3_q;
  assign bus.wd3       = wd3_q;
  assign bus.init_done = (state == S_ARB);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file
// behind the write port.
module tb_regfile_write_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] rf [32];

  regfile_write_arbiter_if #(.NREQ(2)) bus ();

  regfile_write_arbiter #(.NREQ(2), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: commits the port at the edge after it is driven.
  always @(posedge clk) begin
    if (bus.we3 && bus.a3 != 5'd0) rf[bus.a3] <= bus.wd3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we3"}, 32'(bus.we3), 32'(we));
    chk({tag, "_a3"},  32'(bus.a3),  32'(a));
    chk({tag, "_wd3"}, bus.wd3, d);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int r = 0; r < 32; r++) rf[r] = 32'hA5A5A5A5;
    rst           = 1'b1;
    bus.clear     = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // Reset values
    #3;
    chk_port("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_init_done", 32'(bus.init_done), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: power-up sweep
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk_port($sformatf("t1_sweep%0d", i), 1'b1, 5'(i), 32'h0);
      chk($sformatf("t1_init_done%0d", i), 32'(bus.init_done), (i == 31) ? 32'h1 : 32'h0);
    end
    tick();
    chk("t1_idle_we3", 32'(bus.we3), 32'h0);
    chk("t1_idle_init_done", 32'(bus.init_done), 32'h1);
    for (int r = 1; r < 32; r++) chk($sformatf("t1_rf_x%0d", r), rf[r], 32'h0);

    // Test 3: both valid, first arbitration after reset -> 0,1,0,1
    bus.req_valid = 2'b11;
    bus.req_addr  = {5'd4, 5'd3};
    bus.req_data  = {32'h22, 32'h11};
    for (int j = 0; j < 4; j++) begin
      #1;
      chk($sformatf("t3_ready%0d", j), 32'(bus.req_ready), (j % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      if (j % 2 == 0) chk_port($sformatf("t3_port%0d", j), 1'b1, 5'd3, 32'h11);
      else            chk_port($sformatf("t3_port%0d", j), 1'b1, 5'd4, 32'h22);
    end

    // Test 2: single write to x5
    bus.req_valid = 2'b01;
    bus.req_addr  = {5'd0, 5'd5};
    bus.req_data  = {32'h0, 32'hDEADBEEF};
    #1;
    chk("t2_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    chk_port("t2_port", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("t2_rf_x5", rf[5], 32'hDEADBEEF);
    chk("t2_idle_we3", 32'(bus.we3), 32'h0);

    // Test 4: x0 write from requester 1 is consumed and dropped
    bus.req_valid = 2'b10;
    bus.req_addr  = {5'd0, 5'd5};
    bus.req_data  = {32'hFFFFFFFF, 32'h55};
    #1;
    chk("t4_ready_x0", 32'(bus.req_ready), 32'h2);
    tick();
    chk("t4_we3_x0", 32'(bus.we3), 32'h0);
    chk("t4_a3_x0", 32'(bus.a3), 32'h0);
    bus.req_valid = 2'b11;
    #1;
    chk("t4_ready_rr", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    chk_port("t4_port", 1'b1, 5'd5, 32'h55);
    tick();
    chk("t4_rf_x0_untouched", rf[0], 32'hA5A5A5A5);

    // Test 5: clear blocks the grant, re-sweeps, then requester 0 wins
    bus.req_valid = 2'b01;
    bus.req_addr  = {5'd0, 5'd7};
    bus.req_data  = {32'h0, 32'h77};
    bus.clear     = 1'b1;
    #1;
    chk("t5_ready_clear", 32'(bus.req_ready), 32'h0);
    tick();
    bus.clear = 1'b0;
    chk("t5_we3_clear", 32'(bus.we3), 32'h0);
    chk("t5_init_done_clear", 32'(bus.init_done), 32'h0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk_port($sformatf("t5_sweep%0d", i), 1'b1, 5'(i), 32'h0);
      chk($sformatf("t5_init_done%0d", i), 32'(bus.init_done), (i == 31) ? 32'h1 : 32'h0);
      chk($sformatf("t5_ready%0d", i), 32'(bus.req_ready), (i == 31) ? 32'h1 : 32'h0);
    end
    tick();
    bus.req_valid = 2'b00;
    chk_port("t5_port", 1'b1, 5'd7, 32'h77);
    chk("t5_rf_x5_cleared", rf[5], 32'h0);
    tick();

    // Test 6: async reset mid-sweep
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    for (int i = 1; i <= 17; i++) tick();
    chk_port("t6_pre_rst", 1'b1, 5'd17, 32'h0);
    rst = 1'b1;
    #1;
    chk_port("t6_rst", 1'b0, 5'd0, 32'h0);
    chk("t6_rst_init_done", 32'(bus.init_done), 32'h0);
    #1;
    rst = 1'b0;
    tick();
    chk_port("t6_restart1", 1'b1, 5'd1, 32'h0);
    tick();
    chk_port("t6_restart2", 1'b1, 5'd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
